// File: rtl/ccta_result_buf.sv
// rtl/ccta_result_buf.sv - CCTA result FIFO with optional running statistics.
// Optional stats (sum, sum_ovf, max_val) are built only when CCTA_RESULT_STATS_EN is defined.
module ccta_result_buf #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [4:0]    in_data,
    input  logic          in_tag,
    output logic          in_ready,
    output logic          out_valid,
    output logic [4:0]    out_data,
    output logic          out_tag,
    input  logic          out_ready,
    output logic [AW:0]   count,
    output logic [8:0]    sum,
    output logic          sum_ovf,
    output logic [4:0]    max_val
);

    localparam int          DEPTH    = 2 ** AW;
    localparam logic [AW:0] LP_ZERO  = '0;
    localparam logic [AW:0] LP_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] LP_DEPTH = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } state_t;

    state_t          r_state;
    logic [5:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic [4:0]      r_out_data;
    logic            r_out_tag;

    logic            w_push;
    logic            w_pop;
    logic [AW-1:0]   w_rptr_nxt;
    logic [AW:0]     w_count_nxt;
    logic [5:0]      w_head_nxt;

    assign in_ready  = (r_state != ST_FULL) && !flush;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;
    assign count     = r_count;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // The head register is loaded with whatever word will be oldest after this edge;
    // a word written this edge is not yet in r_mem, so it is forwarded from the input.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + LP_ONE;
            2'b01:   w_count_nxt = r_count - LP_ONE;
            default: w_count_nxt = r_count;
        endcase
        w_rptr_nxt = w_pop ? r_rptr + 1'b1 : r_rptr;
        if (w_count_nxt == LP_ZERO)
            w_head_nxt = 6'd0;
        else if (w_push && (w_count_nxt == LP_ONE))
            w_head_nxt = {in_tag, in_data};
        else
            w_head_nxt = r_mem[w_rptr_nxt];
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= {in_tag, in_data};
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state    <= ST_EMPTY;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_out_data <= '0;
            r_out_tag  <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            r_rptr                  <= w_rptr_nxt;
            r_count                 <= w_count_nxt;
            {r_out_tag, r_out_data} <= w_head_nxt;
            case (r_state)
                ST_EMPTY: begin
                    if (w_push)
                        r_state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (w_push && !w_pop && (w_count_nxt == LP_DEPTH))
                        r_state <= ST_FULL;
                    else if (w_pop && !w_push && (w_count_nxt == LP_ZERO))
                        r_state <= ST_EMPTY;
                end
                ST_FULL: begin
                    if (w_pop)
                        r_state <= ST_ACTIVE;
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

`ifdef CCTA_RESULT_STATS_EN
    logic [8:0] r_sum;
    logic       r_sum_ovf;
    logic [4:0] r_max;
    logic [9:0] w_sum_ext;

    assign w_sum_ext = {1'b0, r_sum} + {5'd0, in_data};

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_sum     <= '0;
            r_sum_ovf <= 1'b0;
            r_max     <= '0;
        end else if (w_push) begin
            r_sum <= w_sum_ext[8:0];
            if (w_sum_ext[9])
                r_sum_ovf <= 1'b1;
            if (in_data > r_max)
                r_max <= in_data;
        end
    end

    assign sum     = r_sum;
    assign sum_ovf = r_sum_ovf;
    assign max_val = r_max;
`else
    assign sum     = 9'd0;
    assign sum_ovf = 1'b0;
    assign max_val = 5'd0;
`endif

endmodule
